// File: rtl/serial_add_sub_unit.sv
// rtl/serial_add_sub_unit.sv - bit-serial adder/subtractor with accumulator
module serial_add_sub_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] sum_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       mode_reg;
  logic             carry;
  logic             cout_reg;
  logic             ovf_reg;
  logic             in_fire;
  logic             last_bit;
  logic             fa_a;
  logic             fa_b;
  logic             fa_s;
  logic             fa_c;

  assign in_fire  = in_valid && in_ready;
  assign last_bit = (bit_cnt == CW'(WIDTH - 1));

  // mode[1] selects the accumulator as operand A, mode[0] selects subtraction
  assign op_a = mode_reg[1] ? acc : a_reg;
  assign op_b = mode_reg[0] ? ~b_reg : b_reg;
  assign fa_a = op_a[bit_cnt];
  assign fa_b = op_b[bit_cnt];
  assign fa_s = fa_a ^ fa_b ^ carry;
  assign fa_c = (fa_a & fa_b) | (carry & (fa_a ^ fa_b));

  always_comb begin
    sum_nxt          = sum_reg;
    sum_nxt[bit_cnt] = fa_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_fire) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      mode_reg <= '0;
      acc      <= '0;
      sum_reg  <= '0;
      bit_cnt  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (in_fire) begin
      a_reg    <= a;
      b_reg    <= b;
      mode_reg <= mode;
      carry    <= mode[0] ? 1'b1 : cin;
      bit_cnt  <= '0;
    end else if (state == RUN) begin
      sum_reg <= sum_nxt;
      carry   <= fa_c;
      if (last_bit) begin
        bit_cnt  <= '0;
        cout_reg <= fa_c;
        // carry still holds the carry into the MSB here
        ovf_reg  <= carry ^ fa_c;
        if (mode_reg[1]) acc <= sum_nxt;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// tb/tb_serial_add_sub_unit.sv - directed self-checking bench for serial_add_sub_unit
module tb_serial_add_sub_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] mode;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       busy;

  int n_asserts = 0;
  int n_fails   = 0;

  logic [7:0] r_sum;
  logic       r_cout;
  logic       r_ovf;
  int         r_lat;

  serial_add_sub_unit #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .mode     (mode),
    .cin      (cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation from IDLE, scramble inputs during RUN, wait (bounded) for out_valid.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [1:0] tm,
                        input logic tc);
    a = ta; b = tb_v; mode = tm; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); mode = 2'($urandom); cin = 1'($urandom);
    r_lat = 0;
    while (!out_valid && r_lat < 50) begin
      @(posedge clk); #1;
      r_lat++;
    end
    r_sum = sum; r_cout = cout; r_ovf = ovf;
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".idle_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".idle_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic [1:0] tm, input logic tc,
                       input logic [7:0] es, input logic ec, input logic eo);
    run_op(ta, tb_v, tm, tc);
    check({tag, ".latency"}, 32'(r_lat), 32'd8);
    check({tag, ".sum"}, 32'(r_sum), 32'(es));
    check({tag, ".cout"}, 32'(r_cout), 32'(ec));
    check({tag, ".ovf"}, 32'(r_ovf), 32'(eo));
    release_result(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; mode = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.sum", 32'(sum), 32'd0);
    check("rst.cout", 32'(cout), 32'd0);
    check("rst.ovf", 32'(ovf), 32'd0);

    do_op("add_0f_01", 8'h0F, 8'h01, 2'b00, 1'b0, 8'h10, 1'b0, 1'b0);
    do_op("add_7f_01", 8'h7F, 8'h01, 2'b00, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op("add_ff_01", 8'hFF, 8'h01, 2'b00, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("add_ff_00_cin", 8'hFF, 8'h00, 2'b00, 1'b1, 8'h00, 1'b1, 1'b0);
    do_op("sub_05_07", 8'h05, 8'h07, 2'b01, 1'b1, 8'hFE, 1'b0, 1'b0);
    do_op("sub_80_01", 8'h80, 8'h01, 2'b01, 1'b0, 8'h7F, 1'b1, 1'b1);

    // accumulator sequence from a fresh reset; operand a must be ignored
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    do_op("acc1", 8'hAA, 8'h40, 2'b10, 1'b0, 8'h40, 1'b0, 1'b0);
    do_op("plain_mid", 8'h01, 8'h02, 2'b00, 1'b0, 8'h03, 1'b0, 1'b0);
    do_op("acc2", 8'h55, 8'h40, 2'b10, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op("acc3", 8'h00, 8'h40, 2'b10, 1'b0, 8'hC0, 1'b0, 1'b0);
    do_op("accsub", 8'h33, 8'h40, 2'b11, 1'b0, 8'h80, 1'b1, 1'b0);

    // backpressure: result held, new operands ignored
    run_op(8'h12, 8'h34, 2'b00, 1'b0);
    check("bp.sum", 32'(r_sum), 32'h46);
    in_valid = 1'b1; a = 8'hF0; b = 8'h0F; mode = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.out_valid", 32'(out_valid), 32'd1);
      check("bp.sum_hold", 32'(sum), 32'h46);
      check("bp.in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_result("bp");
    check("bp.sum_after", 32'(sum), 32'h46);

    // reset in the middle of RUN
    a = 8'h11; b = 8'h22; mode = 2'b00; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("midrun.busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midrst.in_ready", 32'(in_ready), 32'd1);
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.sum", 32'(sum), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    do_op("acc_after_rst", 8'h9C, 8'h01, 2'b10, 1'b0, 8'h01, 1'b0, 1'b0);

    // reset wins over a simultaneous handshake
    a = 8'h01; b = 8'h01; mode = 2'b00; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
    check("rst_prio.busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/serial_add_sub_unit.md
SERIAL_ADD_SUB_UNIT -- requirements
Module: serial_add_sub_unit

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  operand set presented.
REQ-005 Port: in_ready  output  1  unit can accept an operand set.
REQ-006 Port: a  input  WIDTH  operand A; ignored in accumulate modes.
REQ-007 Port: b  input  WIDTH  operand B.
REQ-008 Port: mode  input  2  operation select: 00 add, 01 sub, 10 accumulate-add, 11 accumulate-sub.
REQ-009 Port: cin  input  1  carry-in; used by add modes only.
REQ-010 Port: out_valid  output  1  result presented.
REQ-011 Port: out_ready  input  1  consumer accepts the result.
REQ-012 Port: sum  output  WIDTH  result.
REQ-013 Port: cout  output  1  carry out of MSB; in sub modes, 1 means no borrow.
REQ-014 Port: ovf  output  1  two's-complement signed overflow.
REQ-015 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-016 The unit SHALL be an FSM with states IDLE, RUN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; an input handshake is in_valid && in_ready.
REQ-018 On an input handshake, the unit SHALL capture a, b, mode and cin, clear the bit counter and enter RUN.
REQ-019 Operand A SHALL be a in modes 00/01 and the accumulator register in modes 10/11.
REQ-020 Operand B SHALL be b in add modes and ~b in sub modes.
REQ-021 Initial carry SHALL be cin in add modes and 1 in sub modes; cin SHALL be ignored in sub modes.
REQ-022 RUN SHALL process exactly one bit per cycle, LSB first, through a single 1-bit full adder with a registered carry.
REQ-023 RUN SHALL last exactly WIDTH cycles; sum bit i SHALL be produced in RUN cycle i.
REQ-024 On the last RUN cycle, the unit SHALL register cout as the final carry and ovf as (carry into MSB) XOR (carry out of MSB), then enter DONE.
REQ-025 On entering DONE in modes 10/11, the accumulator SHALL load the new sum; modes 00/01 SHALL leave the accumulator unchanged.
REQ-026 out_valid SHALL be 1 only in DONE.
REQ-027 sum, cout and ovf SHALL be held stable while out_valid=1 && out_ready=0.
REQ-028 Latency: if the handshake occurs on edge t, out_valid SHALL rise after edge t+WIDTH.
REQ-029 DONE with out_ready=1 SHALL return to IDLE on the next edge; in_ready SHALL NOT rise in the same cycle as out_valid (no bypass), giving at most one result per WIDTH+2 cycles.
REQ-030 Arithmetic SHALL be modulo 2^WIDTH; sum SHALL wrap with no saturation.
REQ-031 in_valid asserted outside IDLE SHALL be ignored, with no capture and no state change.
REQ-032 Changes on a, b, mode or cin during RUN or DONE SHALL NOT affect the result in progress.

Reset
REQ-033 When rst=1 at a rising edge, the FSM SHALL go to IDLE from any state, including mid-RUN or DONE, and the operation in progress SHALL be discarded.
REQ-034 Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, accumulator=0, bit counter=0, carry=0.
REQ-035 rst SHALL take priority over any simultaneous handshake.

Verification (WIDTH=8)
REQ-036 Add 0x0F+0x01, cin=0, accepted on edge t: out_valid rises after edge t+8, sum=0x10, cout=0, ovf=0.
REQ-037 Add wrap and overflow: 0x7F+0x01 gives sum=0x80, ovf=1, cout=0; 0xFF+0x01 gives sum=0x00, cout=1, ovf=0; 0xFF+0x00 with cin=1 gives sum=0x00, cout=1.
REQ-038 Sub 0x05-0x07 gives sum=0xFE, cout=0, ovf=0; sub 0x80-0x01 gives sum=0x7F, cout=1, ovf=1.
REQ-039 Accumulate after reset, three mode-10 ops with b=0x40: results 0x40 (ovf=0), then 0x80 (ovf=1), then 0xC0; a mode-00 op in between leaves the accumulator unchanged.
REQ-040 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, sum is stable, in_ready=0 and in_valid is ignored; out_ready=1 -> IDLE on the next edge.
REQ-041 Reset on RUN cycle 3 -> the next cycle shows in_ready=1, out_valid=0, sum=0, and an accumulate of 0x01 then yields 0x01.
